pc_sequencer: RTL and testbench

Multi-cycle fetch/redirect sequencer for the sequential core. It owns the architectural PC and fetches one instruction at a time over a valid/ready instruction-memory port. It presents each instruction to decode/execute, then consumes the branch decision and target at retire to choose the next PC. The branch unit produces the redirect; this block acts on it.

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_sequencer_pc_next_calc.sv | 21 ++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/redirect sequencer and the fetch/decode glue.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET_WAIT = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT       = 3'd2,
        ST_EXEC       = 3'd3,
        ST_HALT       = 3'd4
    } seq_state_e;

    localparam int          INSTR_BYTES      = 4;
    localparam int          DEFAULT_XLEN     = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

    // Instructions are word aligned; any set bit in the low two bits is illegal.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory port plus the retire/branch handshake between core and sequencer.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
);
    logic            take_branch;
    logic [XLEN-1:0] branch_target;
    logic            instr_done;
    logic            halt_req;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            halted;
    logic            misalign_err;
    logic [XLEN-1:0] retire_count;

    modport master (
        input  take_branch, branch_target, instr_done, halt_req,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_addr,
        output instr_valid, instr, pc, halted, misalign_err, retire_count
    );

    modport slave (
        output take_branch, branch_target, instr_done, halt_req,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_addr,
        input  instr_valid, instr, pc, halted, misalign_err, retire_count
    );

endinterface

// File: rtl/pc_sequencer_pc_next_calc.sv
// Next-PC selection: sequential increment or branch redirect, with alignment check on the target.
module pc_next_calc
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            take_branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misalign_o
);
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    // The add wraps naturally at XLEN bits, which is the intended behaviour at the top of memory.
    always_comb begin
        next_pc_o  = take_branch_i ? branch_target_i : (pc_i + STEP);
        misalign_o = take_branch_i && is_misaligned(branch_target_i[1:0]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural PC: fetches one instruction, holds it until retire, then redirects or steps.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] next_pc;
    logic            target_misaligned;

    pc_next_calc #(.XLEN(XLEN)) u_next_calc (
        .pc_i            (pc_q),
        .take_branch_i   (bus.take_branch),
        .branch_target_i (bus.branch_target),
        .next_pc_o       (next_pc),
        .misalign_o      (target_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET_WAIT;
            pc_q          <= RESET_PC;
            count_q       <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = misalign_q;

        case (state_q)
            ST_RESET_WAIT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                // An accepted request wins over a halt arriving in the same cycle.
                if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                end else if (bus.halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    instr_d       = bus.imem_rsp_data;
                    instr_valid_d = 1'b1;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.instr_done) begin
                    count_d       = count_q + XLEN'(1);
                    instr_valid_d = 1'b0;
                    if (target_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = bus.halt_req ? ST_HALT : ST_REQ;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RESET_WAIT;
            end
        endcase
    end

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_addr      = pc_q;
    assign bus.pc             = pc_q;
    assign bus.instr          = instr_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.halted         = (state_q == ST_HALT);
    assign bus.misalign_err   = misalign_q;
    assign bus.retire_count   = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: memory responder and core driver feed expectation queues; a monitor pops and compares.
module tb_pc_sequencer;

    localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(64)) bus ();

    pc_sequencer #(.XLEN(64), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic take; logic [63:0] target; logic halt; } plan_t;
    typedef struct { logic [63:0] pc; logic [31:0] word; logic [63:0] cnt; } exec_t;
    typedef struct { logic [63:0] pc; logic mis; logic [63:0] cnt; } halt_t;

    plan_t       plan_q[$];
    logic [63:0] exp_fetch[$];
    exec_t       exp_exec[$];
    halt_t       exp_halt[$];

    int errors = 0;
    int checks = 0;

    logic [63:0] model_pc  = RST_PC;
    logic [63:0] model_cnt = 64'd0;
    int ready_mode    = 1;
    int rsp_delay_fix = 1;
    int stray_pct     = 0;
    int junk_pct      = 0;

    logic        mem_pend  = 1'b0;
    logic        mem_stale = 1'b0;
    int          mem_cnt   = 0;
    logic [63:0] mem_addr  = 64'd0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0] - 32'h0000_1000;
        return 32'h0000_0013 ^ (lo * 32'h0001_0101);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // Instruction memory: accepts per ready_mode, answers after 1..3 cycles, injects stray responses when idle.
    initial begin : mem_model
        logic        acc;
        logic [63:0] acc_addr;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            acc      = rst_n && bus.imem_req_valid && bus.imem_req_ready;
            acc_addr = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            if (acc) begin
                mem_pend  = 1'b1;
                mem_stale = 1'b0;
                mem_addr  = acc_addr;
                mem_cnt   = (rsp_delay_fix != 0) ? rsp_delay_fix : int'($urandom_range(1, 3));
            end
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    exec_t e;
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(mem_addr);
                    mem_pend = 1'b0;
                    if (!mem_stale) begin
                        e.pc = mem_addr; e.word = mem_word(mem_addr); e.cnt = model_cnt;
                        exp_exec.push_back(e);
                    end
                end
            end else if (int'($urandom_range(0, 99)) < stray_pct) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = $urandom;
            end
            case (ready_mode)
                0:       bus.imem_req_ready = 1'($urandom_range(0, 1));
                1:       bus.imem_req_ready = 1'b1;
                default: bus.imem_req_ready = 1'b0;
            endcase
        end
    end

    // Core side: retires the live instruction from the plan queue and updates the reference model.
    initial begin : core_model
        logic drv_halt;
        plan_t p;
        halt_t h;
        logic [63:0] nxt;
        drv_halt          = 1'b0;
        bus.instr_done    = 1'b0;
        bus.take_branch   = 1'b0;
        bus.branch_target = 64'd0;
        bus.halt_req      = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.instr_done) begin
                bus.instr_done    = 1'b0;
                bus.take_branch   = 1'b0;
                bus.branch_target = 64'd0;
                if (drv_halt) bus.halt_req = 1'b0;
                drv_halt = 1'b0;
            end else if (rst_n && bus.instr_valid && plan_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                p = plan_q.pop_front();
                bus.instr_done    = 1'b1;
                bus.take_branch   = p.take;
                bus.branch_target = p.target;
                bus.halt_req      = p.halt;
                drv_halt          = p.halt;
                nxt       = p.take ? p.target : model_pc + 64'd4;
                model_cnt = model_cnt + 64'd1;
                if (p.take && p.target[1:0] != 2'b00) begin
                    h.pc = model_pc; h.mis = 1'b1; h.cnt = model_cnt;
                    exp_halt.push_back(h);
                end else begin
                    model_pc = nxt;
                    if (p.halt) begin
                        h.pc = model_pc; h.mis = 1'b0; h.cnt = model_cnt;
                        exp_halt.push_back(h);
                    end else begin
                        exp_fetch.push_back(model_pc);
                    end
                end
                $display("retire take=%0d target=%h halt=%0d -> model pc=%h count=%0d",
                         p.take, p.target, p.halt, model_pc, model_cnt);
            end else if (rst_n && !bus.instr_valid && int'($urandom_range(0, 99)) < junk_pct) begin
                bus.instr_done    = 1'b1;
                bus.take_branch   = 1'($urandom_range(0, 1));
                bus.branch_target = {$urandom, $urandom};
            end
        end
    end

    // Monitor: samples just after the falling edge, once the drivers have settled.
    initial begin : monitor
        logic        prev_pend, prev_retire, prev_iv, prev_halted;
        logic [63:0] prev_addr, held_pc;
        logic [31:0] held_instr;
        exec_t e;
        halt_t h;
        prev_pend = 0; prev_retire = 0; prev_iv = 0; prev_halted = 0;
        prev_addr = 0; held_pc = 0; held_instr = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_pend = 0; prev_retire = 0; prev_iv = 0; prev_halted = 0;
            end else begin
                if (prev_pend && !bus.halted) begin
                    check64("req_hold_valid", 64'(bus.imem_req_valid), 64'd1);
                    check64("req_hold_addr", bus.imem_addr, prev_addr);
                end
                if (prev_retire)
                    check64("retire_to_req", 64'(bus.imem_req_valid | bus.halted), 64'd1);
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    if (exp_fetch.size() == 0) fail_now("fetch_addr", "unexpected fetch");
                    else check64("fetch_addr", bus.imem_addr, exp_fetch.pop_front());
                    $display("fetch addr=%h", bus.imem_addr);
                end
                if (bus.instr_valid && !prev_iv) begin
                    if (exp_exec.size() == 0) begin
                        fail_now("exec_instr", "unexpected instruction");
                    end else begin
                        e = exp_exec.pop_front();
                        check64("exec_pc", bus.pc, e.pc);
                        check64("exec_instr", 64'(bus.instr), 64'(e.word));
                        check64("exec_count", bus.retire_count, e.cnt);
                        held_pc = e.pc; held_instr = e.word;
                        $display("exec pc=%h instr=%h count=%0d", bus.pc, bus.instr, bus.retire_count);
                    end
                end else if (bus.instr_valid) begin
                    check64("exec_hold_pc", bus.pc, held_pc);
                    check64("exec_hold_instr", 64'(bus.instr), 64'(held_instr));
                end
                if (bus.halted) begin
                    check64("halt_no_req", 64'(bus.imem_req_valid), 64'd0);
                    if (!prev_halted) begin
                        if (exp_halt.size() == 0) begin
                            fail_now("halt", "unexpected halt");
                        end else begin
                            h = exp_halt.pop_front();
                            check64("halt_pc", bus.pc, h.pc);
                            check64("halt_misalign", 64'(bus.misalign_err), 64'(h.mis));
                            check64("halt_count", bus.retire_count, h.cnt);
                            $display("halt pc=%h misalign=%0d count=%0d", bus.pc, bus.misalign_err, bus.retire_count);
                        end
                    end
                end
                prev_pend   = bus.imem_req_valid && !bus.imem_req_ready;
                prev_addr   = bus.imem_addr;
                prev_retire = bus.instr_valid && bus.instr_done;
                prev_iv     = bus.instr_valid;
                prev_halted = bus.halted;
            end
        end
    end

    task automatic do_reset(input int rmode);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        if (mem_pend) mem_stale = 1'b1;
        bus.instr_done    = 1'b0;
        bus.take_branch   = 1'b0;
        bus.branch_target = 64'd0;
        bus.halt_req      = 1'b0;
        plan_q.delete();
        exp_fetch.delete();
        exp_exec.delete();
        exp_halt.delete();
        model_pc   = RST_PC;
        model_cnt  = 64'd0;
        ready_mode = rmode;
        @(negedge clk);
        check64("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check64("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        check64("rst_instr", 64'(bus.instr), 64'd0);
        check64("rst_pc", bus.pc, RST_PC);
        check64("rst_halted", 64'(bus.halted), 64'd0);
        check64("rst_misalign", 64'(bus.misalign_err), 64'd0);
        check64("rst_count", bus.retire_count, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_fetch.push_back(RST_PC);
        @(negedge clk);
        check64("idle_after_reset", 64'(bus.imem_req_valid), 64'd0);
    endtask

    task automatic wait_quiet(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!((plan_q.size() == 0 || bus.halted) && exp_exec.size() == 0 && exp_halt.size() == 0 &&
                 exp_fetch.size() == 0 && !mem_pend && !bus.instr_done) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL timeout_%s: got %0d cycles without settling, limit %0d", tag, n, max_cycles);
        end
    endtask

    task automatic push_plan(input logic take, input logic [63:0] target, input logic halt);
        plan_t p;
        p.take = take; p.target = target; p.halt = halt;
        plan_q.push_back(p);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got simulation still running, limit 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int wait_n;
        // Sequential run of three, then a taken branch
        rsp_delay_fix = 1;
        do_reset(1);
        repeat (3) push_plan(1'b0, 64'd0, 1'b0);
        push_plan(1'b1, 64'h2000, 1'b0);
        wait_quiet("seq_branch", 400);
        check64("final_pc_seq", bus.pc, model_pc);

        // Misaligned redirect halts without moving the PC
        do_reset(1);
        push_plan(1'b1, 64'h2002, 1'b0);
        push_plan(1'b0, 64'd0, 1'b0);
        wait_quiet("misalign", 200);
        repeat (5) @(negedge clk);

        // Slow acceptance, slow response, stray responses while requesting
        rsp_delay_fix = 3;
        stray_pct     = 60;
        do_reset(2);
        repeat (5) @(negedge clk);
        ready_mode = 1;
        push_plan(1'b0, 64'd0, 1'b0);
        wait_quiet("slow_mem", 200);
        stray_pct = 0;

        // Halt together with retire
        rsp_delay_fix = 1;
        do_reset(1);
        push_plan(1'b0, 64'd0, 1'b1);
        wait_quiet("halt_retire", 200);

        // Reset while a fetch is outstanding; the late response must be dropped
        rsp_delay_fix = 3;
        do_reset(1);
        wait_n = 0;
        while (!mem_pend && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check64("reach_wait", 64'(mem_pend), 64'd1);
        do_reset(2);
        repeat (5) @(negedge clk);
        ready_mode = 1;
        push_plan(1'b0, 64'd0, 1'b0);
        wait_quiet("reset_in_wait", 200);

        // Halt request while a request is pending
        rsp_delay_fix = 1;
        do_reset(2);
        @(negedge clk);
        bus.halt_req = 1'b1;
        exp_fetch.delete();
        begin
            halt_t h;
            h.pc = RST_PC; h.mis = 1'b0; h.cnt = 64'd0;
            exp_halt.push_back(h);
        end
        ready_mode = 1;
        wait_quiet("halt_in_req", 100);
        repeat (4) @(negedge clk);

        // Branch to the last word of the address space, then wrap to zero
        do_reset(1);
        push_plan(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push_plan(1'b0, 64'd0, 1'b0);
        push_plan(1'b0, 64'd0, 1'b0);
        wait_quiet("wrap", 300);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            rsp_delay_fix = 0;
            stray_pct     = 15;
            junk_pct      = 15;
            do_reset(0);
            for (int i = 0; i < 25; i++) begin
                logic [63:0] tgt;
                logic        tk;
                tk  = ($urandom_range(0, 2) == 0);
                tgt = {$urandom, $urandom} & ~64'd3;
                if ($urandom_range(0, 39) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                push_plan(tk, tgt, $urandom_range(0, 29) == 0);
            end
            wait_quiet("random", 3000);
            junk_pct  = 0;
            stray_pct = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
